// File: rtl/board_input_ctrl.sv
// Push-button conditioner: two-flop synchronizer, per-key debounce with press/release
// pulses, and a free-running divider producing the slow AUTO-mode clock and its rising-edge tick.
module board_input_ctrl #(
    parameter int NKEYS      = 4,
    parameter int DEB_CYCLES = 280000,
    parameter int DEB_W      = 19,
    parameter int DIV_HALF   = 14000000,
    parameter int DIV_W      = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NKEYS-1:0] key_n,
    input  logic             auto_en,
    output logic [NKEYS-1:0] key_level,
    output logic [NKEYS-1:0] key_press,
    output logic [NKEYS-1:0] key_release,
    output logic             clk_auto,
    output logic             clk_auto_tick
);

    logic [NKEYS-1:0] sync1_reg;
    logic [NKEYS-1:0] sync2_reg;
    logic [NKEYS-1:0] key_s;

    // Flops reset to the released level so a key held through reset is re-debounced.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_reg <= '1;
            sync2_reg <= '1;
        end else begin
            sync1_reg <= key_n;
            sync2_reg <= sync1_reg;
        end
    end

    assign key_s = ~sync2_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NKEYS; gi++) begin : g_deb
            logic [DEB_W-1:0] cnt_reg;
            logic [DEB_W-1:0] cnt_next;
            logic             level_reg;
            logic             level_next;
            logic             press_reg;
            logic             press_next;
            logic             release_reg;
            logic             release_next;

            always_comb begin
                cnt_next     = '0;
                level_next   = level_reg;
                press_next   = 1'b0;
                release_next = 1'b0;
                if (key_s[gi] != level_reg) begin
                    if (cnt_reg == DEB_W'(DEB_CYCLES - 1)) begin
                        level_next   = key_s[gi];
                        press_next   = key_s[gi];
                        release_next = ~key_s[gi];
                    end else begin
                        cnt_next = cnt_reg + DEB_W'(1);
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_reg     <= '0;
                    level_reg   <= 1'b0;
                    press_reg   <= 1'b0;
                    release_reg <= 1'b0;
                end else begin
                    cnt_reg     <= cnt_next;
                    level_reg   <= level_next;
                    press_reg   <= press_next;
                    release_reg <= release_next;
                end
            end

            assign key_level[gi]   = level_reg;
            assign key_press[gi]   = press_reg;
            assign key_release[gi] = release_reg;
        end
    endgenerate

    logic [DIV_W-1:0] div_cnt_reg;
    logic [DIV_W-1:0] div_cnt_next;
    logic             clk_auto_reg;
    logic             clk_auto_next;
    logic             tick_reg;
    logic             tick_next;

    // Tick is registered alongside clk_auto so it marks the cycle clk_auto reads 1.
    always_comb begin
        div_cnt_next  = div_cnt_reg;
        clk_auto_next = clk_auto_reg;
        tick_next     = 1'b0;
        if (auto_en) begin
            if (div_cnt_reg == DIV_W'(DIV_HALF - 1)) begin
                div_cnt_next  = '0;
                clk_auto_next = ~clk_auto_reg;
                tick_next     = ~clk_auto_reg;
            end else begin
                div_cnt_next = div_cnt_reg + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_reg  <= '0;
            clk_auto_reg <= 1'b0;
            tick_reg     <= 1'b0;
        end else begin
            div_cnt_reg  <= div_cnt_next;
            clk_auto_reg <= clk_auto_next;
            tick_reg     <= tick_next;
        end
    end

    assign clk_auto      = clk_auto_reg;
    assign clk_auto_tick = tick_reg;

endmodule

// File: tb/tb_board_input_ctrl.sv
// Directed bench for board_input_ctrl with DEB_CYCLES=4, DIV_HALF=3, plus a DIV_HALF=1 instance.
module tb_board_input_ctrl;

    localparam int NKEYS = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [NKEYS-1:0] key_n;
    logic             auto_en;
    logic [NKEYS-1:0] key_level, key_press, key_release;
    logic             clk_auto, clk_auto_tick;
    logic [NKEYS-1:0] lvl1, prs1, rel1;
    logic             ca1, tk1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    board_input_ctrl #(
        .NKEYS(NKEYS), .DEB_CYCLES(4), .DEB_W(3), .DIV_HALF(3), .DIV_W(2)
    ) dut (
        .clk(clk), .rst(rst), .key_n(key_n), .auto_en(auto_en),
        .key_level(key_level), .key_press(key_press), .key_release(key_release),
        .clk_auto(clk_auto), .clk_auto_tick(clk_auto_tick)
    );

    board_input_ctrl #(
        .NKEYS(NKEYS), .DEB_CYCLES(4), .DEB_W(3), .DIV_HALF(1), .DIV_W(1)
    ) dut_fast (
        .clk(clk), .rst(rst), .key_n(key_n), .auto_en(1'b1),
        .key_level(lvl1), .key_press(prs1), .key_release(rel1),
        .clk_auto(ca1), .clk_auto_tick(tk1)
    );

    typedef struct {
        logic       rst;
        logic [3:0] key_n;
        logic       auto_en;
        logic [3:0] lvl;
        logic [3:0] prs;
        logic [3:0] rel;
        logic       ca;
        logic       tk;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [3:0] kn, input logic ae,
                       input logic [3:0] l, input logic [3:0] p, input logic [3:0] rl,
                       input logic c, input logic t);
        vec_t v;
        v.rst = r; v.key_n = kn; v.auto_en = ae;
        v.lvl = l; v.prs = p; v.rel = rl; v.ca = c; v.tk = t;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; key_n = 4'b1111; auto_en = 1'b0;

        // Reset with all keys held, then release all, then press/release key 1.
        for (int i = 0; i < 3; i++) add(1, 4'b0000, 1, 4'b0000, 4'b0000, 4'b0000, 0, 0);
        add(0, 4'b0000, 1, 4'b0000, 4'b0000, 4'b0000, 0, 0); // k0
        add(0, 4'b0000, 1, 4'b0000, 4'b0000, 4'b0000, 0, 0); // k1
        add(0, 4'b0000, 1, 4'b0000, 4'b0000, 4'b0000, 1, 1); // k2
        add(0, 4'b0000, 1, 4'b0000, 4'b0000, 4'b0000, 1, 0); // k3
        add(0, 4'b0000, 1, 4'b0000, 4'b0000, 4'b0000, 1, 0); // k4
        add(0, 4'b0000, 1, 4'b1111, 4'b1111, 4'b0000, 0, 0); // k5
        add(0, 4'b1111, 1, 4'b1111, 4'b0000, 4'b0000, 0, 0); // k6
        add(0, 4'b1111, 1, 4'b1111, 4'b0000, 4'b0000, 0, 0); // k7
        add(0, 4'b1111, 1, 4'b1111, 4'b0000, 4'b0000, 1, 1); // k8
        add(0, 4'b1111, 1, 4'b1111, 4'b0000, 4'b0000, 1, 0); // k9
        add(0, 4'b1111, 1, 4'b1111, 4'b0000, 4'b0000, 1, 0); // k10
        add(0, 4'b1111, 1, 4'b0000, 4'b0000, 4'b1111, 0, 0); // k11
        add(0, 4'b1101, 1, 4'b0000, 4'b0000, 4'b0000, 0, 0); // k12
        add(0, 4'b1101, 1, 4'b0000, 4'b0000, 4'b0000, 0, 0); // k13
        add(0, 4'b1101, 1, 4'b0000, 4'b0000, 4'b0000, 1, 1); // k14
        add(0, 4'b1101, 1, 4'b0000, 4'b0000, 4'b0000, 1, 0); // k15
        add(0, 4'b1101, 1, 4'b0000, 4'b0000, 4'b0000, 1, 0); // k16
        add(0, 4'b1101, 1, 4'b0010, 4'b0010, 4'b0000, 0, 0); // k17
        add(0, 4'b1111, 1, 4'b0010, 4'b0000, 4'b0000, 0, 0); // k18
        add(0, 4'b1111, 1, 4'b0010, 4'b0000, 4'b0000, 0, 0); // k19
        add(0, 4'b1111, 1, 4'b0010, 4'b0000, 4'b0000, 1, 1); // k20
        add(0, 4'b1111, 1, 4'b0010, 4'b0000, 4'b0000, 1, 0); // k21
        add(0, 4'b1111, 1, 4'b0010, 4'b0000, 4'b0000, 1, 0); // k22
        add(0, 4'b1111, 1, 4'b0000, 4'b0000, 4'b0010, 0, 0); // k23
        add(0, 4'b1111, 1, 4'b0000, 4'b0000, 4'b0000, 0, 0); // k24

        foreach (vecs[i]) begin
            int nerr;
            nerr = errors;
            rst = vecs[i].rst; key_n = vecs[i].key_n; auto_en = vecs[i].auto_en;
            step();
            chk("vec_level",   key_level,     vecs[i].lvl);
            chk("vec_press",   key_press,     vecs[i].prs);
            chk("vec_release", key_release,   vecs[i].rel);
            chk("vec_clk_auto", clk_auto,     vecs[i].ca);
            chk("vec_tick",    clk_auto_tick, vecs[i].tk);
            $display("vec %0d rst=%0b key_n=%b -> level=%b press=%b release=%b clk_auto=%0b tick=%0b %s",
                     i, rst, key_n, key_level, key_press, key_release, clk_auto, clk_auto_tick,
                     (errors == nerr) ? "ok" : "bad");
        end

        // Glitch rejection: key 0 low for 3 sampled cycles must be discarded.
        rst = 1'b1; key_n = 4'b1111; auto_en = 1'b0;
        step(); step();
        rst = 1'b0;
        step(); step();
        for (int e = 0; e < 10; e++) begin
            key_n = (e < 3) ? 4'b1110 : 4'b1111;
            step();
            chk("glitch_level", key_level, 4'b0000);
            chk("glitch_press", key_press, 4'b0000);
        end
        $display("glitch of 3 cycles on key 0 applied, level=%b", key_level);

        // A 4-cycle-stable low is accepted, then its release follows.
        for (int e = 0; e < 10; e++) begin
            key_n = (e < 4) ? 4'b1110 : 4'b1111;
            step();
            chk("accept_level",   key_level,   {3'b000, (e >= 5 && e <= 8)});
            chk("accept_press",   key_press,   {3'b000, (e == 5)});
            chk("accept_release", key_release, {3'b000, (e == 9)});
        end
        $display("4-cycle press on key 0 applied, level=%b", key_level);

        // Independent keys: key 2 at edge 0, key 3 at edge 2.
        for (int e = 0; e < 9; e++) begin
            key_n = (e < 2) ? 4'b1011 : 4'b0011;
            step();
            chk("indep_level", key_level, {(e >= 7), (e >= 5), 2'b00});
            chk("indep_press", key_press, {(e == 7), (e == 5), 2'b00});
        end
        $display("keys 2 and 3 pressed two cycles apart, level=%b", key_level);

        // Divider hold: auto_en drops for edges 4..8 while clk_auto is 1.
        rst = 1'b1; key_n = 4'b1111; auto_en = 1'b1;
        step();
        rst = 1'b0;
        begin
            logic [13:0] exp_ca;
            logic [13:0] exp_tk;
            exp_ca = 14'b10001111111100; // bit e = clk_auto after edge e
            exp_tk = 14'b10000000000100;
            for (int e = 0; e < 14; e++) begin
                auto_en = (e >= 4 && e <= 8) ? 1'b0 : 1'b1;
                step();
                chk("hold_clk_auto", clk_auto, exp_ca[e]);
                chk("hold_tick", clk_auto_tick, exp_tk[e]);
            end
        end
        $display("divider hold sequence done, clk_auto=%0b", clk_auto);

        // Mid-debounce, mid-divide reset with key 3 held throughout.
        auto_en = 1'b0; key_n = 4'b0111;
        for (int e = 0; e < 4; e++) step();
        chk("pre_rst_clk_auto", clk_auto, 1'b1);
        rst = 1'b1;
        step();
        chk("midrst_clk_auto", clk_auto, 1'b0);
        chk("midrst_level", key_level, 4'b0000);
        chk("midrst_tick", clk_auto_tick, 1'b0);
        rst = 1'b0; auto_en = 1'b1;
        for (int k = 0; k < 7; k++) begin
            step();
            chk("rehold_level", key_level, {(k >= 5), 3'b000});
            chk("rehold_press", key_press, {(k == 5), 3'b000});
            chk("rehold_clk_auto", clk_auto, (k >= 2 && k <= 4));
        end
        $display("reset mid-debounce done, level=%b clk_auto=%0b", key_level, clk_auto);

        // DIV_HALF=1 instance: toggles every cycle, tick every other cycle.
        rst = 1'b1;
        step();
        chk("fast_rst_clk_auto", ca1, 1'b0);
        rst = 1'b0;
        for (int e = 0; e < 6; e++) begin
            step();
            chk("fast_clk_auto", ca1, (e % 2 == 0));
            chk("fast_tick", tk1, (e % 2 == 0));
        end
        $display("DIV_HALF=1 instance sequence done, clk_auto=%0b", ca1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/board_input_ctrl.md
Name: board_input_ctrl

Overview:
Input-side board conditioner: the counterpart of the display/LED output path of the board top level. It takes raw active-low push-buttons (KEY) from the 28 MHz board clock domain and produces the following signals:
- synchronized, debounced key levels;
- single-cycle press and release pulses (feeding btStep and btRst);
- the free-running slow clock (clk) used in AUTO mode, with a one-cycle tick marking each of its rising edges.

Parameters:
NKEYS, 4, number of push-buttons handled
DEB_CYCLES, 280000, consecutive stable cycles required to accept a new key level (10 ms at 28 MHz)
DEB_W, 19, width of each debounce counter (must hold DEB_CYCLES-1)
DIV_HALF, 14000000, clk cycles per half-period of clk_auto (1 Hz at 28 MHz)
DIV_W, 24, width of the divider counter (must hold DIV_HALF-1)

Ports:
clk  input  1  board clock (CLK_28 at top level)
rst  input  1  synchronous reset, active-high
key_n  input  NKEYS  raw buttons, asynchronous, active-low (0 = pressed)
auto_en  input  1  1 = divider runs; 0 = divider counter and clk_auto hold
key_level  output  NKEYS  debounced level, 1 = pressed
key_press  output  NKEYS  one-cycle pulse when key_level bit goes 0->1
key_release  output  NKEYS  one-cycle pulse when key_level bit goes 1->0
clk_auto  output  1  divided square wave, period 2*DIV_HALF cycles
clk_auto_tick  output  1  one-cycle pulse in the cycle clk_auto becomes 1

Behaviour:
- All state changes on the rising edge of clk. rst is sampled only on that edge and overrides every other input.
- Reset values:
  - synchronizer flops = 1 (released);
  - key_level, key_press, key_release = 0;
  - debounce counters = 0;
  - divider counter = 0;
  - clk_auto = 0, clk_auto_tick = 0.
- Synchronizer: each key_n bit passes through 2 flops. s = inverted second flop output, so s = 1 means pressed.
- Debounce, per key, fully independent:
  - If s != key_level: counter increments.
  - If s != key_level and counter == DEB_CYCLES-1: key_level <= s and counter <= 0.
  - If s == key_level: counter <= 0. Any glitch shorter than DEB_CYCLES cycles is therefore discarded.
- Latency: a clean level change on key_n first sampled at edge 0 appears on key_level after edge DEB_CYCLES+1.
- key_press / key_release are registered. They are high only in the cycle where key_level shows its new value, and low otherwise. Press and release of the same key never coincide.
- Divider, when auto_en = 1:
  - counter counts 0..DIV_HALF-1, then wraps to 0 and clk_auto toggles on the wrap edge.
  - clk_auto_tick = 1 for exactly the cycle in which clk_auto has just become 1.
- Divider, when auto_en = 0: counter and clk_auto hold their values, clk_auto_tick = 0. Deassert/reassert resumes counting from the held value.
- Reset mid-debounce or mid-divide: all counters are discarded and the block restarts from the reset values. A key held through reset is re-accepted DEB_CYCLES+2 cycles after rst falls, with a key_press pulse.
- DIV_HALF = 1 is legal: clk_auto toggles every cycle and clk_auto_tick is high every other cycle.

Test Plan:
(All with DEB_CYCLES=4, DIV_HALF=3.)
1. Reset: hold rst 3 cycles with key_n=4'b0000 -> all outputs 0 during reset. After release, key_level=4'b1111 after edge 5 with key_press=4'b1111 for that one cycle only.
2. Clean press: key_n[1] 1->0 at edge 0 -> key_level[1]=1 and key_press[1]=1 after edge 5; key_press[1]=0 after edge 6. Release gives key_release[1] with the same timing.
3. Glitch rejection: key_n[0] low for 3 cycles then high -> key_level[0], key_press[0] stay 0 throughout. A subsequent 4-cycle-stable low is accepted.
4. Independent keys: key_n[2] and key_n[3] fall 2 cycles apart -> press pulses 2 cycles apart; key_level of the other keys unaffected.
5. Divider: auto_en=1 from reset -> clk_auto toggles every 3 cycles (period 6). clk_auto_tick=1 on cycles 3, 9, 15 after reset release.
6. Hold and mid-reset: auto_en=0 for 5 cycles mid-count -> clk_auto frozen and tick stays 0; counting resumes where it stopped. Then rst for 1 cycle mid-debounce -> counters cleared, clk_auto=0.
